// File: rtl/nv_nvdla_cacc_reg_pkg.sv
// rtl/nv_nvdla_cacc_reg_pkg.sv - CACC register map constants and group status encodings
package nv_nvdla_cacc_reg_pkg;

    localparam logic [11:0] ADDR_STATUS    = 12'h000;
    localparam logic [11:0] ADDR_POINTER   = 12'h004;
    localparam logic [11:0] ADDR_OP_ENABLE = 12'h008;
    localparam logic [11:0] ADDR_GRP_LO    = 12'h008;
    localparam logic [11:0] ADDR_GRP_HI    = 12'h034;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2
    } grp_status_e;

    function automatic grp_status_e grp_status(input logic op_en, input logic is_consumer);
        if (!op_en) begin
            return ST_IDLE;
        end
        return is_consumer ? ST_RUNNING : ST_PENDING;
    endfunction

    function automatic logic in_grp_window(input logic [11:0] addr);
        return (addr >= ADDR_GRP_LO) && (addr <= ADDR_GRP_HI);
    endfunction

endpackage

// File: rtl/nv_nvdla_cacc_grp_ctrl.sv
// rtl/nv_nvdla_cacc_grp_ctrl.sv - per-group op_en and saturation count tracking
module nv_nvdla_cacc_grp_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_set,
    input  logic        op_clr,
    input  logic [31:0] sat_in,
    output logic        op_en,
    output logic        op_en_nxt,
    output logic [31:0] sat_count
);

    logic        op_en_q;
    logic        op_en_d;
    logic [31:0] sat_count_q;
    logic [31:0] sat_count_d;

    // A software enable landing in the same cycle as layer-done wins over the clear.
    always_comb begin
        op_en_d     = op_en_q;
        sat_count_d = sat_count_q;
        if (op_clr) begin
            op_en_d     = 1'b0;
            sat_count_d = sat_in;
        end
        if (op_set) begin
            op_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_en_q     <= 1'b0;
            sat_count_q <= 32'd0;
        end else begin
            op_en_q     <= op_en_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign op_en     = op_en_q;
    assign op_en_nxt = op_en_d;
    assign sat_count = sat_count_q;

endmodule

// File: rtl/nv_nvdla_cacc_reg_pingpong.sv
// rtl/nv_nvdla_cacc_reg_pingpong.sv - CACC ping-pong register group controller
module nv_nvdla_cacc_reg_pingpong
    import nv_nvdla_cacc_reg_pkg::*;
(
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        req_pvld,
    output logic        req_prdy,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdat,
    input  logic        req_write,
    output logic        rsp_valid,
    output logic        rsp_is_wr,
    output logic [31:0] rsp_rdat,
    output logic [11:0] d0_reg_offset,
    output logic [31:0] d0_reg_wr_data,
    output logic        d0_reg_wr_en,
    input  logic [31:0] d0_reg_rd_data,
    input  logic        d0_op_en_trigger,
    output logic        d0_op_en,
    output logic [31:0] d0_sat_count,
    output logic [11:0] d1_reg_offset,
    output logic [31:0] d1_reg_wr_data,
    output logic        d1_reg_wr_en,
    input  logic [31:0] d1_reg_rd_data,
    input  logic        d1_op_en_trigger,
    output logic        d1_op_en,
    output logic [31:0] d1_sat_count,
    input  logic        dp2reg_done,
    input  logic [31:0] dp2reg_sat_count,
    output logic        reg2dp_op_en,
    output logic        reg2dp_group
);

    logic        producer_q, producer_d;
    logic        consumer_q, consumer_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_is_wr_q, rsp_is_wr_d;
    logic [31:0] rsp_rdat_q, rsp_rdat_d;
    logic        reg2dp_op_en_q, reg2dp_op_en_d;
    logic        reg2dp_group_q, reg2dp_group_d;

    logic [1:0]  op_en;
    logic [1:0]  op_en_nxt;
    logic [1:0]  op_set;
    logic [1:0]  op_clr;
    logic        is_status;
    logic        is_pointer;
    logic        in_window;
    logic        grp_wr;
    logic        done_fire;
    logic [1:0]  st0;
    logic [1:0]  st1;
    logic [31:0] bank_rd_data;

    assign req_prdy = 1'b1;
    assign op_en    = {d1_op_en, d0_op_en};

    // Writes into a running group are dropped, except the op-enable register itself.
    always_comb begin
        is_status    = (req_addr == ADDR_STATUS);
        is_pointer   = (req_addr == ADDR_POINTER);
        in_window    = in_grp_window(req_addr);
        grp_wr       = req_pvld && req_write && in_window &&
                       (!op_en[producer_q] || (req_addr == ADDR_OP_ENABLE));
        bank_rd_data = producer_q ? d1_reg_rd_data : d0_reg_rd_data;
        done_fire    = dp2reg_done && op_en[consumer_q];
        st0          = grp_status(op_en[0], consumer_q == 1'b0);
        st1          = grp_status(op_en[1], consumer_q == 1'b1);
    end

    assign d0_reg_offset  = req_addr;
    assign d1_reg_offset  = req_addr;
    assign d0_reg_wr_data = req_wdat;
    assign d1_reg_wr_data = req_wdat;
    assign d0_reg_wr_en   = grp_wr && !producer_q && nvdla_core_rstn;
    assign d1_reg_wr_en   = grp_wr &&  producer_q && nvdla_core_rstn;

    always_comb begin
        op_set[0] = d0_op_en_trigger && req_wdat[0];
        op_set[1] = d1_op_en_trigger && req_wdat[0];
        op_clr[0] = done_fire && (consumer_q == 1'b0);
        op_clr[1] = done_fire && (consumer_q == 1'b1);
    end

    always_comb begin
        producer_d  = producer_q;
        consumer_d  = consumer_q ^ done_fire;
        rsp_valid_d = req_pvld;
        rsp_is_wr_d = req_pvld && req_write;
        rsp_rdat_d  = 32'd0;
        if (req_pvld && req_write && is_pointer) begin
            producer_d = req_wdat[0];
        end
        if (req_pvld && !req_write) begin
            if (is_status) begin
                rsp_rdat_d = {14'd0, st1, 14'd0, st0};
            end else if (is_pointer) begin
                rsp_rdat_d = {15'd0, consumer_q, 15'd0, producer_q};
            end else if (in_window) begin
                rsp_rdat_d = bank_rd_data;
            end
        end
        reg2dp_op_en_d = op_en_nxt[consumer_d];
        reg2dp_group_d = consumer_d;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            producer_q     <= 1'b0;
            consumer_q     <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_is_wr_q    <= 1'b0;
            rsp_rdat_q     <= 32'd0;
            reg2dp_op_en_q <= 1'b0;
            reg2dp_group_q <= 1'b0;
        end else begin
            producer_q     <= producer_d;
            consumer_q     <= consumer_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_wr_q    <= rsp_is_wr_d;
            rsp_rdat_q     <= rsp_rdat_d;
            reg2dp_op_en_q <= reg2dp_op_en_d;
            reg2dp_group_q <= reg2dp_group_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_wr    = rsp_is_wr_q;
    assign rsp_rdat     = rsp_rdat_q;
    assign reg2dp_op_en = reg2dp_op_en_q;
    assign reg2dp_group = reg2dp_group_q;

    nv_nvdla_cacc_grp_ctrl u_grp0 (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .op_set    (op_set[0]),
        .op_clr    (op_clr[0]),
        .sat_in    (dp2reg_sat_count),
        .op_en     (d0_op_en),
        .op_en_nxt (op_en_nxt[0]),
        .sat_count (d0_sat_count)
    );

    nv_nvdla_cacc_grp_ctrl u_grp1 (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .op_set    (op_set[1]),
        .op_clr    (op_clr[1]),
        .sat_in    (dp2reg_sat_count),
        .op_en     (d1_op_en),
        .op_en_nxt (op_en_nxt[1]),
        .sat_count (d1_sat_count)
    );

endmodule

// File: tb/tb_nv_nvdla_cacc_reg_pingpong.sv
// tb/tb_nv_nvdla_cacc_reg_pingpong.sv - randomized self-checking bench for the CACC ping-pong registers
module tb_nv_nvdla_cacc_reg_pingpong;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_pvld;
    logic        req_prdy;
    logic [11:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_is_wr;
    logic [31:0] rsp_rdat;
    logic [11:0] d0_reg_offset, d1_reg_offset;
    logic [31:0] d0_reg_wr_data, d1_reg_wr_data;
    logic        d0_reg_wr_en, d1_reg_wr_en;
    logic [31:0] d0_reg_rd_data, d1_reg_rd_data;
    logic        d0_op_en_trigger, d1_op_en_trigger;
    logic        d0_op_en, d1_op_en;
    logic [31:0] d0_sat_count, d1_sat_count;
    logic        dp2reg_done;
    logic [31:0] dp2reg_sat_count;
    logic        reg2dp_op_en;
    logic        reg2dp_group;

    int n_chk  = 0;
    int n_fail = 0;

    logic        init_bank;
    logic [31:0] bank0 [16];
    logic [31:0] bank1 [16];

    bit          m_prod;
    bit          m_cons;
    bit          m_op   [2];
    logic [31:0] m_sat  [2];
    logic [31:0] m_mem  [2][16];

    always #5 clk = ~clk;

    nv_nvdla_cacc_reg_pingpong dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .req_pvld         (req_pvld),
        .req_prdy         (req_prdy),
        .req_addr         (req_addr),
        .req_wdat         (req_wdat),
        .req_write        (req_write),
        .rsp_valid        (rsp_valid),
        .rsp_is_wr        (rsp_is_wr),
        .rsp_rdat         (rsp_rdat),
        .d0_reg_offset    (d0_reg_offset),
        .d0_reg_wr_data   (d0_reg_wr_data),
        .d0_reg_wr_en     (d0_reg_wr_en),
        .d0_reg_rd_data   (d0_reg_rd_data),
        .d0_op_en_trigger (d0_op_en_trigger),
        .d0_op_en         (d0_op_en),
        .d0_sat_count     (d0_sat_count),
        .d1_reg_offset    (d1_reg_offset),
        .d1_reg_wr_data   (d1_reg_wr_data),
        .d1_reg_wr_en     (d1_reg_wr_en),
        .d1_reg_rd_data   (d1_reg_rd_data),
        .d1_op_en_trigger (d1_op_en_trigger),
        .d1_op_en         (d1_op_en),
        .d1_sat_count     (d1_sat_count),
        .dp2reg_done      (dp2reg_done),
        .dp2reg_sat_count (dp2reg_sat_count),
        .reg2dp_op_en     (reg2dp_op_en),
        .reg2dp_group     (reg2dp_group)
    );

    // Stand-in register banks
    assign d0_reg_rd_data   = bank0[d0_reg_offset[5:2]];
    assign d1_reg_rd_data   = bank1[d1_reg_offset[5:2]];
    assign d0_op_en_trigger = d0_reg_wr_en && (d0_reg_offset == 12'h008);
    assign d1_op_en_trigger = d1_reg_wr_en && (d1_reg_offset == 12'h008);

    always @(posedge clk) begin
        if (init_bank) begin
            for (int i = 0; i < 16; i++) begin
                bank0[i] <= 32'hB0B0_0000 | 32'(i);
                bank1[i] <= 32'hB1B1_0000 | 32'(i);
            end
        end else begin
            if (d0_reg_wr_en) bank0[d0_reg_offset[5:2]] <= d0_reg_wr_data;
            if (d1_reg_wr_en) bank1[d1_reg_offset[5:2]] <= d1_reg_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_status(input int g);
        if (!m_op[g]) return 2'd0;
        return (int'(m_cons) == g) ? 2'd1 : 2'd2;
    endfunction

    task automatic idle_inputs();
        req_pvld         = 1'b0;
        req_write        = 1'b0;
        req_addr         = 12'h000;
        req_wdat         = 32'd0;
        dp2reg_done      = 1'b0;
        dp2reg_sat_count = 32'd0;
    endtask

    task automatic model_reset();
        m_prod = 1'b0;
        m_cons = 1'b0;
        for (int g = 0; g < 2; g++) begin
            m_op[g]  = 1'b0;
            m_sat[g] = 32'd0;
        end
    endtask

    task automatic check_state();
        chk("reg2dp_group", reg2dp_group, m_cons);
        chk("reg2dp_op_en", reg2dp_op_en, m_op[m_cons]);
        chk("d0_op_en", d0_op_en, m_op[0]);
        chk("d1_op_en", d1_op_en, m_op[1]);
        chk("d0_sat_count", d0_sat_count, m_sat[0]);
        chk("d1_sat_count", d1_sat_count, m_sat[1]);
    endtask

    // Entered just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit pvld, input bit wr, input logic [11:0] addr,
                        input logic [31:0] wdat, input bit done, input logic [31:0] sat);
        bit          in_win;
        bit          wr_ok;
        bit          fire;
        int          set_g;
        logic [31:0] e_rdat;
        req_pvld         = pvld;
        req_write        = wr;
        req_addr         = addr;
        req_wdat         = wdat;
        dp2reg_done      = done;
        dp2reg_sat_count = sat;
        in_win = (addr >= 12'h008) && (addr <= 12'h034);
        wr_ok  = pvld && wr && in_win && (!m_op[m_prod] || addr == 12'h008);
        e_rdat = 32'd0;
        if (pvld && !wr) begin
            if (addr == 12'h000)      e_rdat = {14'd0, exp_status(1), 14'd0, exp_status(0)};
            else if (addr == 12'h004) e_rdat = {15'd0, m_cons, 15'd0, m_prod};
            else if (in_win)          e_rdat = m_mem[m_prod][addr[5:2]];
        end
        #1;
        chk("d0_reg_wr_en", d0_reg_wr_en, wr_ok && !m_prod);
        chk("d1_reg_wr_en", d1_reg_wr_en, wr_ok && m_prod);
        set_g = -1;
        if (wr_ok) begin
            m_mem[m_prod][addr[5:2]] = wdat;
            if (addr == 12'h008 && wdat[0]) set_g = int'(m_prod);
        end
        fire = done && m_op[m_cons];
        if (fire) begin
            m_op[m_cons]  = 1'b0;
            m_sat[m_cons] = sat;
            m_cons        = !m_cons;
        end
        if (set_g >= 0) m_op[set_g] = 1'b1;
        if (pvld && wr && addr == 12'h004) m_prod = wdat[0];
        @(posedge clk);
        #1;
        chk("rsp_valid", rsp_valid, pvld);
        if (pvld) begin
            chk("rsp_is_wr", rsp_is_wr, wr);
            chk("rsp_rdat", rsp_rdat, e_rdat);
        end
        check_state();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 32'd0);
        chk({tag, "_rsp_rdat"}, rsp_rdat, 32'd0);
        chk({tag, "_d0_wr_en"}, d0_reg_wr_en, 32'd0);
        chk({tag, "_d1_wr_en"}, d1_reg_wr_en, 32'd0);
        check_state();
    endtask

    initial begin
        logic [11:0] a;
        rstn      = 1'b0;
        init_bank = 1'b1;
        idle_inputs();
        model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[0][i] = 32'hB0B0_0000 | 32'(i);
            m_mem[1][i] = 32'hB1B1_0000 | 32'(i);
        end
        req_pvld  = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h010;
        req_wdat  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        idle_inputs();
        init_bank = 1'b0;
        rstn      = 1'b1;
        @(negedge clk);

        step(1, 0, 12'h000, 32'd0, 0, 32'd0);
        step(1, 0, 12'h004, 32'd0, 0, 32'd0);
        step(1, 1, 12'h004, 32'd1, 0, 32'd0);
        step(1, 1, 12'h010, 32'h0020_0040, 0, 32'd0);
        step(1, 0, 12'h010, 32'd0, 0, 32'd0);
        step(1, 1, 12'h004, 32'd0, 0, 32'd0);
        step(1, 1, 12'h008, 32'd1, 0, 32'd0);
        step(1, 1, 12'h004, 32'd1, 0, 32'd0);
        step(1, 1, 12'h008, 32'd1, 0, 32'd0);
        step(1, 0, 12'h000, 32'd0, 0, 32'd0);
        chk("status_both_on", rsp_rdat, 32'h0002_0001);
        step(0, 0, 12'h000, 32'd0, 1, 32'h0000_0123);
        chk("sat0_latched", d0_sat_count, 32'h0000_0123);
        step(1, 0, 12'h000, 32'd0, 0, 32'd0);
        chk("status_after_done", rsp_rdat, 32'h0001_0000);
        step(1, 1, 12'h004, 32'd0, 0, 32'd0);
        step(1, 1, 12'h008, 32'd1, 0, 32'd0);
        step(1, 1, 12'h010, 32'hDEAD_BEEF, 0, 32'd0);
        step(1, 0, 12'h010, 32'd0, 0, 32'd0);
        step(0, 0, 12'h000, 32'd0, 1, 32'h0000_0456);
        step(0, 0, 12'h000, 32'd0, 1, 32'h0000_0789);
        step(0, 0, 12'h000, 32'd0, 1, 32'h0000_0ABC);
        step(1, 1, 12'h004, 32'd1, 0, 32'd0);
        step(1, 1, 12'h008, 32'd1, 0, 32'd0);
        step(1, 1, 12'h008, 32'd1, 1, 32'h0000_0DEF);
        step(1, 0, 12'h038, 32'd0, 0, 32'd0);
        step(1, 1, 12'hFFC, 32'hFFFF_FFFF, 0, 32'd0);

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 12'h000;
                1:       a = 12'h004;
                2:       a = 12'h008;
                7:       a = 12'h038;
                8:       a = 12'hFFC;
                9:       a = 12'h100;
                default: a = 12'(12'h008 + 4 * $urandom_range(0, 11));
            endcase
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, $urandom,
                 $urandom_range(0, 4) == 0, $urandom);
        end

        req_pvld  = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h014;
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req_write = 1'b1;
        req_addr  = 12'h010;
        #1;
        model_reset();
        check_reset_values("mid");
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("no_stale_rsp", rsp_valid, 32'd0);
        @(negedge clk);
        step(1, 0, 12'h004, 32'd0, 0, 32'd0);
        step(1, 0, 12'h000, 32'd0, 0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cacc_reg_pingpong.md
NV_NVDLA_CACC_REG_PINGPONG -- requirements
Module: nv_nvdla_cacc_reg_pingpong

Interface
REQ-001 SHALL have exactly one clock and one reset: nvdla_core_clk  in  1  core clock; nvdla_core_rstn  in  1  reset, asynchronous, active-low.
REQ-002 SHALL provide the request port: req_pvld  in  1  request valid; req_prdy  out  1  request ready; req_addr  in  12  byte offset; req_wdat  in  32  write data; req_write  in  1  1=write, 0=read.
REQ-003 SHALL provide the response port: rsp_valid  out  1  response valid; rsp_is_wr  out  1  1=write ack; rsp_rdat  out  32  read data (0 on a write ack).
REQ-004 SHALL drive the per-group register-bank ports for g in {0,1}: dg_reg_offset  out  12  offset; dg_reg_wr_data  out  32  write data; dg_reg_wr_en  out  1  write strobe; dg_reg_rd_data  in  32  bank read data; dg_op_en_trigger  in  1  op-enable register written; dg_op_en  out  1  group enable; dg_sat_count  out  32  latched saturation count.
REQ-005 SHALL connect to the datapath: dp2reg_done  in  1  one-cycle layer-done pulse; dp2reg_sat_count  in  32  saturation count of the finishing layer; reg2dp_op_en  out  1  enable of consumer group; reg2dp_group  out  1  consumer pointer.

Function
REQ-006 SHALL tie req_prdy to 1; a request is accepted on any cycle with req_pvld=1.
REQ-007 SHALL assert rsp_valid exactly one cycle after each accepted request (reads and writes); it SHALL be 0 otherwise.
REQ-008 SHALL decode offset 0x000 as S_STATUS (read-only): bits[1:0]=group0 status, bits[17:16]=group1 status; 0=idle (op_en=0), 1=running (op_en=1, consumer==g), 2=pending (op_en=1, consumer!=g).
REQ-009 SHALL decode offset 0x004 as S_POINTER: bit0=producer (read/write), bit16=consumer (read-only).
REQ-010 SHALL route offsets 0x008..0x034 to the bank selected by producer: dg_reg_wr_en pulses for one cycle on the accepted write; reads return dg_reg_rd_data of the producer bank.
REQ-011 SHALL suppress dg_reg_wr_en for a write to group g while dg_op_en=1 (except offset 0x008) and SHALL still return the write ack.
REQ-012 SHALL return 0 for reads of any undecoded offset and SHALL ignore writes to it, still responding.
REQ-013 SHALL set op_en[g] on the cycle after dg_op_en_trigger with written data bit0=1; bit0=0 SHALL have no effect.
REQ-014 SHALL, on dp2reg_done with op_en[consumer]=1: clear op_en[consumer], latch dp2reg_sat_count into dg_sat_count[consumer], and toggle consumer; all three take effect on the next cycle.
REQ-015 SHALL ignore dp2reg_done when op_en[consumer]=0.
REQ-016 SHALL give set priority when set and clear of the same group occur in one cycle; consumer still toggles.
REQ-017 SHALL drive reg2dp_op_en=op_en[consumer] and reg2dp_group=consumer, registered, with no combinational path from any input.
REQ-018 SHALL leave producer unchanged by done events; only a software write to S_POINTER changes it.

Reset
REQ-019 SHALL, on nvdla_core_rstn low, asynchronously force: producer=0, consumer=0, op_en[1:0]=0, dg_sat_count=0, rsp_valid=0, rsp_rdat=0, dg_reg_wr_en=0.
REQ-020 SHALL discard any in-flight response on reset mid-operation; no response SHALL appear after reset release for a pre-reset request.

Structure
REQ-021 SHALL place address constants (0x000, 0x004, group window bounds) and status encodings (IDLE/RUNNING/PENDING) in the shared CACC register package.
REQ-022 SHALL implement per-group op_en and sat_count tracking in one sub-module, nv_nvdla_cacc_grp_ctrl, instantiated twice; banks are instantiated by the parent.

Verification
REQ-023 Reset, then read 0x000 and 0x004 -> rsp_rdat=0x00000000 both, rsp_valid one cycle after each request.
REQ-024 Write 0x004=1, write 0x010=0x00200040 -> d1_reg_wr_en pulses once, d0_reg_wr_en stays 0; read 0x010 returns d1_reg_rd_data.
REQ-025 Trigger op_en group0, then group1 -> S_STATUS=0x00020001; reg2dp_op_en=1, reg2dp_group=0.
REQ-026 dp2reg_done with dp2reg_sat_count=0x0000_0123 -> next cycle d0_sat_count=0x123, d0_op_en=0, reg2dp_group=1, S_STATUS=0x00010000.
REQ-027 Write 0x010 to group0 while d0_op_en=1 -> no d0_reg_wr_en, write ack returned; dp2reg_done with op_en[consumer]=0 -> no state change.
REQ-028 Assert nvdla_core_rstn low one cycle after a read request -> no rsp_valid; all outputs at REQ-019 values.
